// File: rtl/xor_parity_pkg.sv
// Shared definitions for the XOR parity accumulator: FSM state encoding and
// the default data width / frame length used by xor_parity_accum.
package xor_parity_pkg;

   // Frame FSM: no words yet, frame open with at least one word, result shown.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH     = 8;
   localparam int DEFAULT_FRAME_LEN = 4;

endpackage : xor_parity_pkg

// File: rtl/xor_nand_cell.sv
// Two-input XOR built only from four 2-input NAND gates. Used by
// xor_parity_accum when the XOR_NAND_EN macro is defined.
module xor_nand_cell (
   input  logic a,
   input  logic b,
   output logic y
);

   logic n_ab;
   logic n_a;
   logic n_b;

   assign n_ab = ~(a & b);
   assign n_a  = ~(a & n_ab);
   assign n_b  = ~(b & n_ab);
   assign y    = ~(n_a & n_b);

endmodule : xor_nand_cell

// File: rtl/xor_parity_accum.sv
// XOR parity accumulator: folds up to FRAME_LEN words of WIDTH bits into a
// bitwise XOR, closing early on in_last, and presents parity, reduction bit
// and word count with a valid/ready handshake.
// Build option: define XOR_NAND_EN to implement every XOR bit (accumulate
// and reduction) with xor_nand_cell instances instead of the ^ operator.
module xor_parity_accum
   import xor_parity_pkg::*;
#(
   parameter int  WIDTH     = DEFAULT_WIDTH,
   parameter int  FRAME_LEN = DEFAULT_FRAME_LEN,
   localparam int CW        = $clog2(FRAME_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_parity,
   output logic             out_bit,
   output logic [CW-1:0]    out_count
);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_next;

   logic             accept;
   logic             closing;
   logic [WIDTH-1:0] acc_base;
   logic [WIDTH-1:0] acc_xor;

   assign in_ready  = (state != HOLD);
   assign out_valid = (state == HOLD);
   assign accept    = in_valid && in_ready;
   // A frame closes on the accept that fills it or that carries in_last.
   assign closing   = accept && (in_last || (count == CW'(FRAME_LEN - 1)));

   // The first word of a frame starts a fresh accumulation.
   assign acc_base  = (state == IDLE) ? '0 : acc;

   // Result fields are forced to zero while no result is presented.
   assign out_parity = out_valid ? acc : '0;
   assign out_count  = out_valid ? count : '0;

`ifdef XOR_NAND_EN
   logic [WIDTH-1:0] red_chain;

   // Per-bit accumulate through NAND-built XOR cells.
   for (genvar i = 0; i < WIDTH; i++) begin : g_acc_xor
      xor_nand_cell u_acc_cell (
         .a (acc_base[i]),
         .b (in_data[i]),
         .y (acc_xor[i])
      );
   end

   // Reduction XOR of the presented parity as a linear chain of cells.
   assign red_chain[0] = out_parity[0];
   for (genvar i = 1; i < WIDTH; i++) begin : g_red_xor
      xor_nand_cell u_red_cell (
         .a (red_chain[i-1]),
         .b (out_parity[i]),
         .y (red_chain[i])
      );
   end
   assign out_bit = red_chain[WIDTH-1];
`else
   assign acc_xor = acc_base ^ in_data;
   assign out_bit = ^out_parity;
`endif

   // State, accumulator and counter registers with synchronous reset.
   // NOTE: every register here is plain state (no memory array), so all of it
   // is reset; non-blocking assignments keep each edge reading old values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         count <= '0;
      end else begin
         state <= state_next;
         acc   <= acc_next;
         count <= count_next;
      end
   end

   // Next-state logic: accumulate on accept, hold the result until taken.
   // NOTE: defaults first so every path assigns every output (no latches).
   always_comb begin
      state_next = state;
      acc_next   = acc;
      count_next = count;
      unique case (state)
         IDLE, ACCUM: begin
            if (accept) begin
               acc_next   = acc_xor;
               count_next = count + CW'(1);
               state_next = closing ? HOLD : ACCUM;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_next = IDLE;
               acc_next   = '0;
               count_next = '0;
            end
         end
         default: begin
            state_next = IDLE;
            acc_next   = '0;
            count_next = '0;
         end
      endcase
   end

endmodule : xor_parity_accum

// File: tb/tb_xor_parity_accum.sv
// Self-checking bench for xor_parity_accum (WIDTH=8, FRAME_LEN=4): directed
// frames with literal expectations plus a randomized phase, all compared
// every cycle against a word-list reference model.
module tb_xor_parity_accum;

   localparam int WIDTH     = 8;
   localparam int FRAME_LEN = 4;
   localparam int CW        = $clog2(FRAME_LEN + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_parity;
   logic             out_bit;
   logic [CW-1:0]    out_count;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   xor_parity_accum #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_parity (out_parity),
      .out_bit    (out_bit),
      .out_count  (out_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: the list of words accepted in the open frame, and the
   // frame result once it has been closed.
   logic [WIDTH-1:0] m_words [FRAME_LEN];
   int               m_n        = 0;
   bit               m_hold     = 1'b0;
   logic [WIDTH-1:0] m_res_par  = '0;
   int               m_res_cnt  = 0;

   function automatic logic [WIDTH-1:0] fold_words(input int n);
      logic [WIDTH-1:0] p = '0;
      for (int k = 0; k < n; k++) p = p ^ m_words[k];
      return p;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_hold <= 1'b0;
         m_n    <= 0;
      end else if (m_hold) begin
         if (out_ready) begin
            m_hold <= 1'b0;
            m_n    <= 0;
         end
      end else if (in_valid) begin
         m_words[m_n] <= in_data;
         if (in_last || (m_n + 1 == FRAME_LEN)) begin
            m_hold    <= 1'b1;
            m_res_par <= fold_words(m_n) ^ in_data;
            m_res_cnt <= m_n + 1;
            m_n       <= 0;
         end else begin
            m_n <= m_n + 1;
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (check_en) begin
         logic [WIDTH-1:0] e_par;
         e_par = m_hold ? m_res_par : '0;
         check("in_ready",   int'(in_ready),   int'(!m_hold));
         check("out_valid",  int'(out_valid),  int'(m_hold));
         check("out_parity", int'(out_parity), int'(e_par));
         check("out_bit",    int'(out_bit),    $countones(e_par) % 2);
         check("out_count",  int'(out_count),  m_hold ? m_res_cnt : 0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [WIDTH-1:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      step();
   endtask

   task automatic go_idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   // Literal result check at the negedge following the closing accept.
   task automatic expect_result(input string tag, input int par, input int bitv, input int cnt);
      @(negedge clk);
      check({tag, "_valid"},  int'(out_valid),  1);
      check({tag, "_parity"}, int'(out_parity), par);
      check({tag, "_bit"},    int'(out_bit),    bitv);
      check({tag, "_count"},  int'(out_count),  cnt);
   endtask

   initial begin
      rst       = 1'b1;
      out_ready = 1'b1;
      go_idle();
      step();
      check_en = 1'b1;
      step();
      rst = 1'b0;

      // Reset state.
      @(negedge clk);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_in_ready",  int'(in_ready),  1);
      check("rst_parity",    int'(out_parity), 0);
      check("rst_count",     int'(out_count),  0);
      step();

      // Full frame back-to-back.
      send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h04, 1'b0); send(8'h08, 1'b0);
      go_idle();
      expect_result("full", 'h0F, 0, 4);
      step();
      @(negedge clk);
      check("full_back_idle", int'(in_ready), 1);
      step();

      // Early close with two words, then a single-word frame.
      send(8'hFF, 1'b0); send(8'h0F, 1'b1);
      go_idle();
      expect_result("early2", 'hF0, 0, 2);
      step();
      send(8'h80, 1'b1);
      go_idle();
      expect_result("early1", 'h80, 1, 1);
      step();

      // Backpressure: result held for 5 cycles while input pulses are refused.
      out_ready = 1'b0;
      send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h44, 1'b0); send(8'h88, 1'b0);
      for (int c = 0; c < 5; c++) begin
         in_valid = c[0];
         in_data  = 8'(c * 37);
         in_last  = 1'b0;
         @(negedge clk);
         check("bp_in_ready", int'(in_ready),   0);
         check("bp_parity",   int'(out_parity), 'hFF);
         check("bp_count",    int'(out_count),  4);
         step();
      end
      go_idle();
      out_ready = 1'b1;
      step();
      @(negedge clk);
      check("bp_release_valid", int'(out_valid), 0);
      check("bp_release_ready", int'(in_ready),  1);

      // Mid-frame reset discards a partial frame.
      step();
      send(8'hAA, 1'b0); send(8'h55, 1'b0);
      go_idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("mrst_valid",  int'(out_valid),  0);
      check("mrst_ready",  int'(in_ready),   1);
      check("mrst_parity", int'(out_parity), 0);
      check("mrst_count",  int'(out_count),  0);
      step();
      send(8'hAA, 1'b0); send(8'h55, 1'b0); send(8'h00, 1'b0); send(8'h01, 1'b0);
      go_idle();
      expect_result("mrst_frame", 'hFE, 1, 4);
      step();

      // Idle gaps inside a frame.
      send(8'h03, 1'b0);
      go_idle();
      step(); step(); step();
      send(8'h05, 1'b0); send(8'h06, 1'b0); send(8'h00, 1'b0);
      go_idle();
      expect_result("gaps", 'h00, 0, 4);
      step();

      // Randomized traffic checked by the model.
      for (int c = 0; c < 2000; c++) begin
         rst       = ($urandom_range(0, 59) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 8'($urandom);
         in_last   = ($urandom_range(0, 4) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      rst = 1'b0;
      go_idle();
      out_ready = 1'b1;
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_xor_parity_accum

// File: doc/xor_parity_accum.md
XOR_PARITY_ACCUM -- requirements
Module: xor_parity_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter FRAME_LEN, default 4, maximum words per frame (>=1).
REQ-003 SHALL have localparam CW = $clog2(FRAME_LEN+1), the word-count width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  input word present.
REQ-007 SHALL have port in_ready  output  1  block can accept a word.
REQ-008 SHALL have port in_data  input  WIDTH  input word.
REQ-009 SHALL have port in_last  input  1  accepted word closes the frame early.
REQ-010 SHALL have port out_valid  output  1  frame result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port out_parity  output  WIDTH  bitwise XOR of all frame words.
REQ-013 SHALL have port out_bit  output  1  reduction XOR of out_parity.
REQ-014 SHALL have port out_count  output  CW  number of words in the frame.

Function
REQ-015 SHALL implement FSM states IDLE (no words), ACCUM (>=1 word, frame open), HOLD (result presented).
REQ-016 SHALL treat a word as accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-017 SHALL drive in_ready=1 in IDLE and ACCUM, and 0 in HOLD.
REQ-018 SHALL, on each accept, set acc <= acc ^ in_data (acc = in_data when in IDLE) and count <= count+1.
REQ-019 SHALL close the frame on the accept that makes count==FRAME_LEN or that carries in_last=1, whichever comes first.
REQ-020 SHALL move IDLE->ACCUM on a non-closing accept, IDLE/ACCUM->HOLD on a closing accept, and stay otherwise.
REQ-021 SHALL assert out_valid on the cycle after the closing accept (latency 1) and hold out_valid, out_parity, out_bit and out_count stable until out_valid && out_ready.
REQ-022 SHALL, on the output handshake, go HOLD->IDLE and clear acc and count; the next input is accepted one cycle later (no same-cycle bypass).
REQ-023 SHALL leave acc unchanged on idle-cycle gaps (in_valid=0) in ACCUM, with no timeout.
REQ-024 SHALL ignore in_last when in_valid=0 or in_ready=0.
REQ-025 SHALL drive out_parity, out_bit and out_count to 0 whenever out_valid=0.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, enter IDLE with acc=0, count=0, out_valid=0 and in_ready=1 on the following cycle, from any state.
REQ-027 SHALL let rst override any simultaneous accept or output handshake; a partial frame is discarded.

Configuration
REQ-028 SHALL, with macro XOR_NAND_EN defined, compute every XOR bit (accumulate and reduction) through instances of xor_nand_cell, built only from four 2-input NANDs.
REQ-029 SHALL, without XOR_NAND_EN, use the native XOR operator; cycle behaviour and outputs SHALL be identical in both builds.

Structure
REQ-030 SHALL place the FSM state enum (IDLE, ACCUM, HOLD) and the default WIDTH/FRAME_LEN constants in shared package xor_parity_pkg.
REQ-031 SHALL use exactly one sub-module, xor_nand_cell (a, b -> y), instantiated only under XOR_NAND_EN.

Verification (WIDTH=8, FRAME_LEN=4)
REQ-032 SHALL cover a full frame: 0x01,0x02,0x04,0x08 back-to-back with out_ready=1 -> one cycle after the 4th accept, out_valid=1, out_parity=0x0F, out_bit=0, out_count=4.
REQ-033 SHALL cover early close: 0xFF then 0x0F with in_last=1 -> out_parity=0xF0, out_bit=0, out_count=2; a single word 0x80 with in_last=1 -> 0x80, out_bit=1, out_count=1.
REQ-034 SHALL cover backpressure: out_ready=0 for 5 cycles in HOLD -> outputs stable, in_ready=0, in_valid pulses not accepted; out_ready=1 -> IDLE next cycle.
REQ-035 SHALL cover mid-frame reset: rst after 2 words -> all outputs 0 and in_ready=1 next cycle; then frame 0xAA,0x55,0x00,0x01 -> out_parity=0xFE, out_bit=1, out_count=4.
REQ-036 SHALL cover gaps: 0x03, 3 idle cycles, 0x05, 0x06, 0x00 -> out_parity=0x00, out_bit=0, out_count=4.
REQ-037 SHALL run REQ-032..REQ-036 with and without XOR_NAND_EN, with identical cycle-by-cycle outputs in both builds.
